alu_core_seq: RTL

ALU_CORE_SEQ -- requirements
Module: alu_core_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_iter_unit.sv | 83 ++++++++
 rtl/alu_core_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation modes, FSM states and
// the iteration counter sizing helper.
package alu_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    // Bits needed to count iterations 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit
// per step. The result port shows the value after the step being applied now.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [OUT_W-1:0] result
);

    // acc: product accumulator / partial remainder
    // sh : shifted multiplicand / divisor
    // mq : multiplier bits / dividend shifting out, quotient shifting in
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        acc_d   = acc_q;
        sh_d    = sh_q;
        mq_d    = mq_q;
        div_d   = div_q;
        shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial   = shifted - {1'b0, sh_q[WIDTH-1:0]};

        if (start) begin
            div_d = div_sel;
            acc_d = '0;
            if (div_sel) begin
                sh_d = {{WIDTH{1'b0}}, b_in};
                mq_d = a_in;
            end else begin
                sh_d = {{WIDTH{1'b0}}, a_in};
                mq_d = b_in;
            end
        end else if (step) begin
            if (div_q) begin
                // trial[WIDTH] is the borrow: set means the divisor did not fit
                if (!trial[WIDTH]) begin
                    acc_d = {{(OUT_W-WIDTH-1){1'b0}}, trial};
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {{(OUT_W-WIDTH-1){1'b0}}, shifted};
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mq_q[0]) begin
                    acc_d = acc_q + sh_q;
                end
                sh_d = sh_q << 1;
                mq_d = mq_q >> 1;
            end
        end

        result = div_q ? {acc_d[WIDTH-1:0], mq_d} : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sh_q  <= '0;
            mq_q  <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            mq_q  <= mq_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_core_seq.sv
// Sequential ALU: ADD/SUB finish in one edge, MUL/DIV iterate WIDTH edges in
// the shared iteration unit. Handshake: start is honoured only in IDLE; done
// pulses for one cycle in DONE with out/div_by_zero valid and held afterwards.
module alu_core_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [OUT_W-1:0] out,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             iter_start;
    logic             iter_step;
    logic [OUT_W-1:0] iter_result;

    alu_iter_unit #(
        .WIDTH(WIDTH),
        .OUT_W(OUT_W)
    ) u_iter (
        .clk    (slow_clock),
        .rst_n  (reset),
        .start  (iter_start),
        .step   (iter_step),
        .div_sel(mode == MODE_DIV),
        .a_in   (A),
        .b_in   (B),
        .result (iter_result)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        dbz_d      = dbz_q;
        iter_start = 1'b0;
        iter_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (mode)
                        MODE_ADD: begin
                            out_d   = {{WIDTH{1'b0}}, A} + {{WIDTH{1'b0}}, B};
                            dbz_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        MODE_SUB: begin
                            out_d   = {{WIDTH{1'b0}}, A} - {{WIDTH{1'b0}}, B};
                            dbz_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        default: begin
                            if (mode == MODE_DIV && B == '0) begin
                                out_d   = {A, {WIDTH{1'b1}}};
                                dbz_d   = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                iter_start = 1'b1;
                                cnt_d      = '0;
                                state_d    = ST_EXEC;
                            end
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                iter_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = iter_result;
                    dbz_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out         = out_q;
    assign state       = state_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
